spart_rx: RTL and testbench

Serial receive half of the SPART. Oversamples the asynchronous `rxd` line from the host, deserializes 8N1 frames and buffers received bytes in a small first-word-fall-through FIFO. The FIFO is drained by the processor's SPART read path. `rcv` drives the processor's receive-interrupt input (`spart_RCV`), which vectors to the SPART handler. Runs entirely on the 100 MHz core clock.

---
 rtl/spart_rx_pkg.sv | 18 +
 rtl/spart_rx_fifo.sv | 48 ++++
 rtl/spart_rx.sv | 152 +++++++++++++++
 tb/tb_spart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spart_rx_pkg.sv
// Shared SPART definitions: receive FSM states and serial framing constants.
// Also intended for use by the transmit half.
package spart_rx_pkg;

  // 100 MHz core clock divided down to 115200 baud.
  localparam int SPART_CLK_DIV = 868;

  // Start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/spart_rx_fifo.sv
// First-word-fall-through FIFO with extended-pointer full/empty detection.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; dout is masked while empty, so stale words never leak.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: synchronizes rxd, samples 8N1 frames at bit centre and
// queues good bytes in a FWFT FIFO with sticky overrun/framing error flags.
module spart_rx
  import spart_rx_pkg::*;
#(
  parameter int CLK_DIV    = SPART_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd,
  input  logic       clr_err,
  output logic       rcv,
  output logic [7:0] rx_data,
  output logic       overrun,
  output logic       frame_err
);

  localparam int               CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(FRAME_BITS - 3);

  logic rxd_meta;
  logic rxd_s;

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             expired;
  logic             push;
  logic             frame_set;
  logic             overrun_set;
  logic             fifo_empty;
  logic             fifo_full;

  // Idle-high reset keeps a reset release from looking like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  assign expired = (cnt == '0);

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push        = 1'b0;
    frame_set   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = START;
        end
      end

      START: begin
        if (!expired) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (rxd_s) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end

      DATA: begin
        if (!expired) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          shift_nxt = {rxd_s, shift[7:1]};
          cnt_nxt   = FULL_LOAD;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end

      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (!expired) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          if (rxd_s) push = 1'b1;
          else frame_set = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  spart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rd),
    .din  (shift),
    .dout (rx_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // A concurrent pop frees the slot, so only an unaccompanied push into a full FIFO is lost.
  assign overrun_set = push && fifo_full && !rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign rcv = !fifo_empty;

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: frames are modelled as a bounded byte queue
// with sticky error flags; a negedge monitor checks every pop against it.
module tb_spart_rx;

  localparam int BIT_CYC = 16;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd;
  logic       clr_err;
  logic       rcv;
  logic [7:0] rx_data;
  logic       overrun;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_fe  = 1'b0;

  spart_rx #(
    .CLK_DIV   (BIT_CYC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rd       (rd),
    .clr_err  (clr_err),
    .rcv      (rcv),
    .rx_data  (rx_data),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame either lands in a DEPTH-entry queue, overflows it, or is a framing error.
  task automatic model_frame(input logic [7:0] data, input logic stop_bit);
    if (!stop_bit) exp_fe = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else exp_ovr = 1'b1;
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    rxd = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit rd_at_stop);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CYC);
    if (rd_at_stop) begin
      // Stop bit is sampled on the 11th edge of its bit period; pop on exactly that edge.
      rxd = stop_bit;
      repeat (10) @(posedge clk);
      #1 rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
      repeat (BIT_CYC - 11) @(posedge clk);
      #1;
    end else begin
      drive_bit(stop_bit, BIT_CYC);
    end
    model_frame(data, stop_bit);
  endtask

  task automatic idle(input int cycles);
    drive_bit(1'b1, cycles);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rcv"},       rcv,       exp_q.size() != 0);
    check({tag, ".rx_data"},   rx_data,   (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    check({tag, ".overrun"},   overrun,   exp_ovr);
    check({tag, ".frame_err"}, frame_err, exp_fe);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    repeat (n) pulse_rd();
    check_state(tag);
  endtask

  // Monitor: each accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd) begin
      if (exp_q.size() != 0) begin
        check("pop.rcv", rcv, 1'b1);
        check("pop.data", rx_data, exp_q.pop_front());
      end else begin
        check("pop_empty.rcv", rcv, 1'b0);
        check("pop_empty.data", rx_data, 8'h00);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int n;

    rst = 1'b1; rxd = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;
    idle(8);

    // Single frame with start-to-rcv latency measurement.
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (n < 200 && !rcv) begin
          @(negedge clk);
          n++;
        end
      end
    join
    check("a5.latency_in_range", (n >= 150 && n <= 160), 1'b1);
    check_state("a5");
    drain("a5.drain");
    pulse_rd();

    // Short low pulse is rejected as a glitch.
    drive_bit(1'b0, 4);
    idle(200);
    check_state("glitch");

    // Five back-to-back frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_state("ovr");
    drain("ovr.drain");
    pulse_rd();
    pulse_clr();
    check_state("ovr.clr");

    // Bad stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * BIT_CYC);
    check_state("ferr");
    send_frame(8'h7E, 1'b1, 1'b0);
    check_state("ferr.next");
    drain("ferr.drain");
    pulse_clr();
    check_state("ferr.clr");

    // Pop on the very edge that pushes into a full FIFO.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    check_state("edge");
    drain("edge.drain");

    // Reset in the middle of a frame while the FIFO holds a byte.
    send_frame(8'h99, 1'b1, 1'b0);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CYC);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    check_state("midrst");
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(BIT_CYC);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_state("postrst");
    drain("postrst.drain");

    // Randomized frames with random gaps and opportunistic draining.
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 7) != 0), 1'b0);
      if ($urandom_range(0, 2) == 0) idle(BIT_CYC + $urandom_range(0, 20));
      check_state("rand");
      if ($urandom_range(0, 1) == 1) drain("rand.drain");
    end
    idle(BIT_CYC);
    drain("rand.final");
    pulse_clr();
    check_state("rand.clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
